// File: rtl/apb_rr_pkg.sv
// Shared types and default widths for the
// two-requester round-robin APB master.
package apb_rr_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

endpackage

// File: rtl/apb_rr_arb.sv
// 2-way round-robin arbiter.
// req/mask in, last = previous grant index, gnt one-hot out.
module apb_rr_arb (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] gnt
);

  logic [1:0] act;

  assign act = req & ~mask;

  always_comb begin
    gnt = 2'b00;
    case (act)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // on a tie the requester not served last wins
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by two requesters, round-robin.
// i_* requester side, o_p*/i_p* APB side, o_done/o_rdata/o_err result.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int TMO = 15
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic [1:0]      i_req,
  input  logic [1:0]      i_wr,
  input  logic [2*AW-1:0] i_addr,
  input  logic [2*DW-1:0] i_wdata,
  input  logic [2*(DW/8)-1:0] i_strb,
  output logic [1:0]      o_done,
  output logic [DW-1:0]   o_rdata,
  output logic            o_err,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [(DW/8)-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TMO + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          psel_q, psel_d;
  logic          pen_q, pen_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [1:0]    gnt;
  logic          g;
  logic [SW-1:0] strb_g;

  // the requester finishing this cycle is masked
  apb_rr_arb u_arb (
    .req  (i_req),
    .mask (done_q),
    .last (last_q),
    .gnt  (gnt)
  );

  assign g      = gnt[1];
  assign strb_g = g ? i_strb[2*SW-1:SW]
                    : i_strb[SW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sel_d    = sel_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    done_d   = 2'b00;
    rdata_d  = '0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          sel_d    = g;
          pwrite_d = i_wr[g];
          paddr_d  = g ? i_addr[2*AW-1:AW]
                        : i_addr[AW-1:0];
          pwdata_d = g ? i_wdata[2*DW-1:DW]
                        : i_wdata[DW-1:0];
          pstrb_d  = i_wr[g] ? strb_g : '0;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (i_pready) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          done_d  = sel_q ? 2'b10 : 2'b01;
          rdata_d = pwrite_q ? '0 : i_prdata;
          err_d   = i_pslverr;
          last_d  = sel_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // give up on a slave that never answers
          if (cnt_d == CW'(TMO)) begin
            psel_d  = 1'b0;
            pen_d   = 1'b0;
            done_d  = sel_q ? 2'b10 : 2'b01;
            err_d   = 1'b1;
            last_d  = sel_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      done_q   <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_done    = done_q;
  assign o_rdata   = rdata_q;
  assign o_err     = err_q;
  assign o_paddr   = paddr_q;
  assign o_pwrite  = pwrite_q;
  assign o_psel    = psel_q;
  assign o_penable = pen_q;
  assign o_pwdata  = pwdata_q;
  assign o_pstrb   = pstrb_q;

endmodule
